// File: rtl/btn_scan_scheduler.sv
// One shared debounce engine time-multiplexed over N_BTN buttons, plus a
// round-robin press-event queue presented over a valid/ready handshake.
module btn_scan_scheduler #(
    parameter  int N_BTN        = 4,
    parameter  int STABLE_TICKS = 20,
    parameter  int CNT_W        = 5,
    localparam int ID_W         = ($clog2(N_BTN) < 1) ? 1 : $clog2(N_BTN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_in,
    input  logic             tick_mf,
    output logic [N_BTN-1:0] btn_level,
    output logic             evt_valid,
    output logic [ID_W-1:0]  evt_id,
    input  logic             evt_ready,
    output logic             evt_ovf
);

    localparam logic [ID_W-1:0]  LAST    = ID_W'(N_BTN - 1);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(STABLE_TICKS - 1);

    logic [N_BTN-1:0]            sync1, s;
    logic [ID_W-1:0]             ch, rr;
    logic [N_BTN-1:0][CNT_W-1:0] cnt;
    logic [N_BTN-1:0]            pend, press, clr;
    logic                        slot_free, found;
    logic [ID_W-1:0]             pick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            s     <= '0;
        end else begin
            sync1 <= btn_in;
            s     <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       ch <= '0;
        else if (tick_mf) ch <= (ch == LAST) ? '0 : ch + 1'b1;
    end

    // Per-button stability counter and level; only the visited channel moves.
    for (genvar k = 0; k < N_BTN; k++) begin : g_ch
        logic             visit, lvl_q;
        logic [CNT_W-1:0] cnt_q;

        assign visit        = tick_mf && (ch == ID_W'(k));
        assign press[k]     = visit && s[k] && !lvl_q && (cnt_q == CNT_TOP);
        assign btn_level[k] = lvl_q;
        assign cnt[k]       = cnt_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lvl_q <= 1'b0;
                cnt_q <= '0;
            end else if (visit) begin
                if (s[k] == lvl_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_TOP) begin
                    lvl_q <= ~lvl_q;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign slot_free = !evt_valid || evt_ready;

    // First pending index at or above rr, wrapping.
    always_comb begin
        int idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 0; i < N_BTN; i++) begin
            idx = (int'(rr) + i) % N_BTN;
            if (!found && pend[idx]) begin
                found = 1'b1;
                pick  = ID_W'(idx);
            end
        end
    end

    always_comb begin
        clr = '0;
        if (slot_free && found) clr[pick] = 1'b1;
    end

    // A new press wins over a same-cycle clear, so it is never counted lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend    <= '0;
            evt_ovf <= 1'b0;
        end else begin
            pend <= (pend & ~clr) | press;
            if (|(press & pend & ~clr)) evt_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_valid <= 1'b0;
            evt_id    <= '0;
            rr        <= '0;
        end else if (slot_free) begin
            if (found) begin
                evt_valid <= 1'b1;
                evt_id    <= pick;
                rr        <= (pick == LAST) ? '0 : pick + 1'b1;
            end else begin
                evt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_btn_scan_scheduler.sv
// Randomized + directed bench for btn_scan_scheduler with a cycle model
// built from the scan/debounce/arbitration rules.
module tb_btn_scan_scheduler;

    localparam int N  = 4;
    localparam int ST = 3;

    logic         clk, rst_n, tick_mf, evt_ready;
    logic [N-1:0] btn_in, btn_level;
    logic         evt_valid, evt_ovf;
    logic [1:0]   evt_id;

    int tests = 0;
    int fails = 0;

    btn_scan_scheduler #(.N_BTN(N), .STABLE_TICKS(ST), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .tick_mf(tick_mf),
        .btn_level(btn_level), .evt_valid(evt_valid), .evt_id(evt_id),
        .evt_ready(evt_ready), .evt_ovf(evt_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        tick_mf = 1'b0;
        forever begin
            @(negedge clk);
            tick_mf = ~tick_mf;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: s is btn_in delayed two edges; a channel flips after
    // ST consecutive mismatching visits; presses queue as a pending set.
    bit [N-1:0] m_s1, m_s, m_lvl, m_pend, m_press;
    int         m_run[N];
    int         m_ch, m_rr, m_id, m_pick;
    bit         m_valid, m_ovf;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_s1 = '0; m_s = '0; m_lvl = '0; m_pend = '0;
                for (int k = 0; k < N; k++) m_run[k] = 0;
                m_ch = 0; m_rr = 0; m_id = 0; m_valid = 0; m_ovf = 0;
            end else begin
                m_press = '0;
                if (tick_mf) begin
                    if (m_s[m_ch] == m_lvl[m_ch]) begin
                        m_run[m_ch] = 0;
                    end else begin
                        m_run[m_ch] = m_run[m_ch] + 1;
                        if (m_run[m_ch] == ST) begin
                            m_run[m_ch] = 0;
                            m_lvl[m_ch] = ~m_lvl[m_ch];
                            m_press[m_ch] = m_lvl[m_ch];
                        end
                    end
                    m_ch = (m_ch + 1) % N;
                end
                if (!m_valid || evt_ready) begin
                    m_pick = -1;
                    for (int i = 0; i < N; i++)
                        if (m_pick < 0 && m_pend[(m_rr + i) % N]) m_pick = (m_rr + i) % N;
                    if (m_pick >= 0) begin
                        m_valid = 1; m_id = m_pick; m_pend[m_pick] = 0;
                        m_rr = (m_pick + 1) % N;
                    end else begin
                        m_valid = 0;
                    end
                end
                for (int k = 0; k < N; k++)
                    if (m_press[k]) begin
                        if (m_pend[k]) m_ovf = 1;
                        else m_pend[k] = 1;
                    end
                m_s = m_s1;
                m_s1 = btn_in;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            chk("btn_level", btn_level, m_lvl);
            chk("evt_valid", evt_valid, m_valid);
            chk("evt_ovf", evt_ovf, m_ovf);
            if (m_valid) chk("evt_id", evt_id, m_id);
        end
    end

    int ev_q[$];
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (rst_n && evt_valid && evt_ready) ev_q.push_back(int'(evt_id));
        end
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    int held, mask, n2;

    initial begin
        rst_n = 1'b0; btn_in = 4'hF; evt_ready = 1'b1;
        // reset with all buttons held
        clks(6);
        chk("rst_level", btn_level, 0);
        chk("rst_valid", evt_valid, 0);
        chk("rst_id", evt_id, 0);
        chk("rst_ovf", evt_ovf, 0);
        ev_q.delete();
        rst_n = 1'b1;
        clks(16);
        chk("early_level", btn_level, 0);
        clks(32);
        chk("late_level", btn_level, 4'hF);
        chk("rst_evts", ev_q.size(), 4);

        // clean press on btn0
        btn_in = 4'h0;
        clks(32);
        chk("released", btn_level, 0);
        ev_q.delete();
        btn_in = 4'h1;
        clks(32);
        chk("press0_level", btn_level, 4'h1);
        chk("press0_cnt", ev_q.size(), 1);
        if (ev_q.size() > 0) chk("press0_id", ev_q[0], 0);
        clks(16);
        chk("press0_once", ev_q.size(), 1);

        // bounce on btn1: exactly two visits of ch1 see it high
        btn_in = 4'h3;
        clks(16);
        btn_in = 4'h1;
        clks(32);
        chk("bounce_level", btn_level, 4'h1);
        chk("bounce_evts", ev_q.size(), 1);
        chk("bounce_cnt", dut.cnt, 0);

        // arbitration under stall
        btn_in = 4'h0;
        clks(32);
        evt_ready = 1'b0;
        ev_q.delete();
        btn_in = 4'b1101;
        clks(40);
        chk("arb_valid", evt_valid, 1);
        held = int'(evt_id);
        for (int i = 0; i < 10; i++) begin
            clks(1);
            chk("arb_hold", evt_id, held);
        end
        evt_ready = 1'b1;
        clks(6);
        chk("arb_n", ev_q.size(), 3);
        mask = 0;
        foreach (ev_q[i]) mask |= (1 << ev_q[i]);
        chk("arb_ids", mask, 4'b1101);
        chk("arb_idle", evt_valid, 0);

        // overflow: slot holds press 1, pend holds press 2, press 3 is lost
        btn_in = 4'h0;
        clks(40);
        evt_ready = 1'b0;
        ev_q.delete();
        for (int p = 0; p < 3; p++) begin
            btn_in = 4'h4; clks(32);
            if (p == 1) chk("ovf_not_yet", evt_ovf, 0);
            btn_in = 4'h0; clks(32);
        end
        chk("ovf_set", evt_ovf, 1);
        evt_ready = 1'b1;
        clks(10);
        n2 = 0;
        foreach (ev_q[i]) if (ev_q[i] == 2) n2++;
        chk("ovf_evts", n2, 2);
        chk("ovf_sticky", evt_ovf, 1);

        // random traffic
        for (int r = 0; r < 60; r++) begin
            btn_in = 4'($urandom_range(0, 15));
            evt_ready = 1'($urandom_range(0, 1));
            clks($urandom_range(4, 40));
        end

        // reset mid-operation with an unaccepted event
        evt_ready = 1'b0; btn_in = 4'h0;
        clks(40);
        btn_in = 4'h2;
        clks(40);
        chk("mid_valid_pre", evt_valid, 1);
        btn_in = 4'hA;
        clks(10);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_valid", evt_valid, 0);
        chk("mid_ovf", evt_ovf, 0);
        chk("mid_level", btn_level, 0);
        chk("mid_pend", dut.pend, 0);
        chk("mid_cnt", dut.cnt, 0);
        clks(4);
        rst_n = 1'b1; evt_ready = 1'b1;
        clks(60);
        chk("post_level", btn_level, 4'hA);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
